// File: rtl/obstacle_field_generator.sv
// obstacle_field_generator
//   Keeps a scrolling NUM_ROWS x NUM_LANES field of half-block obstacle cells.
//   On each frame tick the field scrolls by 'speed' depth units. When the scroll
//   crosses a row boundary the field shifts down one row and a new top row is
//   spawned from a free-running 64-bit Galois LFSR. Every occupied cell is then
//   streamed to the renderer over valid/ready, followed by a one-cycle done.
//
// Ports
//   clk        sole clock
//   rst_n      asynchronous active-low reset
//   activate   one-cycle frame tick (only honoured while idle)
//   speed      depth units to scroll this frame
//   ready      renderer accepts the presented obstacle
//   valid      obstacle holds an occupied cell
//   first_row  presented cell lies in row 0
//   obstacle   {back_half, type[2:0], lane, depth}
//   done       one-cycle end-of-frame pulse
module obstacle_field_generator #(
  parameter int          NUM_LANES    = 3,
  parameter int          NUM_ROWS     = 16,
  parameter int          ROW_DEPTH    = 64,
  parameter int          DEPTH_W      = 11,
  parameter int          SPAWN_THRESH = 32,
  parameter logic [63:0] SEED         = 64'h1,
  parameter int          LANE_W       = $clog2(NUM_LANES)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           activate,
  input  logic [$clog2(ROW_DEPTH)-1:0]   speed,
  input  logic                           ready,
  output logic                           valid,
  output logic                           first_row,
  output logic [DEPTH_W+LANE_W+3:0]      obstacle,
  output logic                           done
);

  localparam int          OFF_W     = $clog2(ROW_DEPTH);
  localparam int          ROW_W     = $clog2(NUM_ROWS);
  localparam int          TOP       = NUM_ROWS - 1;
  localparam int          OBS_W     = DEPTH_W + LANE_W + 4;
  // A zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [63:0] SEED_EFF  = (SEED == 64'h0) ? 64'h1 : SEED;
  // Right-shift Galois form of x^64 + x^63 + x^61 + x^60 + 1.
  localparam logic [63:0] LFSR_MASK = 64'hD800_0000_0000_0000;
  localparam logic [8:0]  THRESH    = 9'(SPAWN_THRESH);

  localparam logic [2:0]  T_EMPTY   = 3'b000;
  localparam logic [2:0]  T_LOW     = 3'b001;
  localparam logic [2:0]  T_HIGH    = 3'b010;
  localparam logic [2:0]  T_MIDDLE  = 3'b011;
  localparam logic [2:0]  T_TRAIN   = 3'b100;
  localparam logic [2:0]  T_RAMP    = 3'b101;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SCROLL = 3'd1,
    SHIFT  = 3'd2,
    GEN    = 3'd3,
    EMIT   = 3'd4,
    DONE   = 3'd5
  } state_t;

  function automatic logic [63:0] lfsr_next(input logic [63:0] s);
    return {1'b0, s[63:1]} ^ (s[0] ? LFSR_MASK : 64'h0);
  endfunction

  function automatic logic [2:0] decode_type(input logic [2:0] t);
    logic [2:0] ty;
    case (t)
      3'd0:                 ty = T_LOW;
      3'd1:                 ty = T_HIGH;
      3'd2, 3'd3:           ty = T_MIDDLE;
      3'd4, 3'd5, 3'd6:     ty = T_TRAIN;
      3'd7:                 ty = T_RAMP;
      default:              ty = T_LOW;
    endcase
    return ty;
  endfunction

  function automatic logic is_two_row(input logic [2:0] ty);
    return (ty == T_TRAIN) || (ty == T_RAMP);
  endfunction

  // Distance from the viewer to the near edge of a row, wrapped to DEPTH_W bits.
  function automatic logic [DEPTH_W-1:0] depth_of(input logic [ROW_W-1:0] row,
                                                  input logic [OFF_W-1:0] off);
    return DEPTH_W'((32'(row) + 32'd1) * 32'(ROW_DEPTH) - 32'(off));
  endfunction

  state_t             state_r, state_nxt_s;
  logic [ROW_W-1:0]   row_r, row_nxt_s;
  logic [LANE_W-1:0]  lane_r, lane_nxt_s;
  logic [OFF_W-1:0]   offset_r, offset_nxt_s;
  logic [OFF_W:0]     sum_s;
  logic [63:0]        lfsr_r;

  // Cell = {back_half, type}; pending back half = {valid, type}.
  logic [3:0]         cell_r [NUM_ROWS][NUM_LANES];
  logic [3:0]         pend_r [NUM_LANES];

  logic [NUM_LANES-1:0] top_occ_s, spawn_raw_s, spawn_s;
  logic [2:0]           spawn_type_s [NUM_LANES];
  logic                 suppressed_s;

  logic               valid_r, first_row_r, done_r;
  logic [OBS_W-1:0]   obstacle_r;
  logic [3:0]         cell_sel_s;
  logic               out_valid_s;
  logic [OBS_W-1:0]   out_obs_s;

  // Spawn decision for the new top row, including the passability rule.
  always_comb begin
    top_occ_s    = {NUM_LANES{1'b0}};
    spawn_raw_s  = {NUM_LANES{1'b0}};
    spawn_s      = {NUM_LANES{1'b0}};
    suppressed_s = 1'b0;
    for (int j = 0; j < NUM_LANES; j++) begin
      spawn_type_s[j] = decode_type(lfsr_r[11*j+8 +: 3]);
      top_occ_s[j]    = (cell_r[TOP][j][2:0] != T_EMPTY);
      spawn_raw_s[j]  = ({1'b0, lfsr_r[11*j +: 8]} < THRESH) && !top_occ_s[j] &&
                        (cell_r[NUM_ROWS-2][j][2:0] == T_EMPTY);
    end
    spawn_s = spawn_raw_s;
    // A fully blocked top row would be impassable: drop the highest spawning lane.
    if ((&(top_occ_s | spawn_raw_s)) && (|spawn_raw_s)) begin
      for (int j = NUM_LANES - 1; j >= 0; j--) begin
        if (spawn_raw_s[j] && !suppressed_s) begin
          spawn_s[j]   = 1'b0;
          suppressed_s = 1'b1;
        end else begin
          suppressed_s = suppressed_s;
        end
      end
    end else begin
      spawn_s = spawn_raw_s;
    end
  end

  // Next-state, scan index and scroll offset.
  always_comb begin
    state_nxt_s  = state_r;
    row_nxt_s    = row_r;
    lane_nxt_s   = lane_r;
    offset_nxt_s = offset_r;
    sum_s        = {1'b0, offset_r} + {1'b0, speed};
    case (state_r)
      IDLE: begin
        if (activate) begin
          state_nxt_s = SCROLL;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SCROLL: begin
        // ROW_DEPTH is a power of two, so the carry bit is the wrap flag.
        offset_nxt_s = sum_s[OFF_W-1:0];
        row_nxt_s    = {ROW_W{1'b0}};
        lane_nxt_s   = {LANE_W{1'b0}};
        if (sum_s[OFF_W]) begin
          state_nxt_s = SHIFT;
        end else begin
          state_nxt_s = EMIT;
        end
      end
      SHIFT: begin
        state_nxt_s = GEN;
      end
      GEN: begin
        state_nxt_s = EMIT;
        row_nxt_s   = {ROW_W{1'b0}};
        lane_nxt_s  = {LANE_W{1'b0}};
      end
      EMIT: begin
        // Empty cells pass in one cycle; occupied cells wait for ready.
        if (!valid_r || ready) begin
          if ((row_r == ROW_W'(NUM_ROWS - 1)) && (lane_r == LANE_W'(NUM_LANES - 1))) begin
            state_nxt_s = DONE;
          end else if (lane_r == LANE_W'(NUM_LANES - 1)) begin
            lane_nxt_s = {LANE_W{1'b0}};
            row_nxt_s  = row_r + ROW_W'(1);
          end else begin
            lane_nxt_s = lane_r + LANE_W'(1);
          end
        end else begin
          state_nxt_s = EMIT;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Output look-ahead: present the cell the scan will point at after this edge.
  // The field is never written on an edge that enters or stays in EMIT except the
  // top row at GEN->EMIT, which is never the row being selected there.
  always_comb begin
    cell_sel_s  = cell_r[row_nxt_s][lane_nxt_s];
    out_valid_s = (state_nxt_s == EMIT) && (cell_sel_s[2:0] != T_EMPTY);
    if (out_valid_s) begin
      out_obs_s = {cell_sel_s, lane_nxt_s, depth_of(row_nxt_s, offset_nxt_s)};
    end else begin
      out_obs_s = {OBS_W{1'b0}};
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Scan index, scroll offset and free-running LFSR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_r    <= {ROW_W{1'b0}};
      lane_r   <= {LANE_W{1'b0}};
      offset_r <= {OFF_W{1'b0}};
      lfsr_r   <= SEED_EFF;
    end else begin
      row_r    <= row_nxt_s;
      lane_r   <= lane_nxt_s;
      offset_r <= offset_nxt_s;
      lfsr_r   <= lfsr_next(lfsr_r);
    end
  end

  // Field storage: row shift with pending back halves, then top-row spawn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ROWS; i++) begin
        for (int j = 0; j < NUM_LANES; j++) begin
          cell_r[i][j] <= 4'h0;
        end
      end
      for (int j = 0; j < NUM_LANES; j++) begin
        pend_r[j] <= 4'h0;
      end
    end else begin
      case (state_r)
        SHIFT: begin
          for (int i = 0; i < NUM_ROWS - 1; i++) begin
            for (int j = 0; j < NUM_LANES; j++) begin
              cell_r[i][j] <= cell_r[i+1][j];
            end
          end
          for (int j = 0; j < NUM_LANES; j++) begin
            cell_r[TOP][j] <= pend_r[j][3] ? {1'b1, pend_r[j][2:0]} : 4'h0;
            pend_r[j]      <= 4'h0;
          end
        end
        GEN: begin
          for (int j = 0; j < NUM_LANES; j++) begin
            if (spawn_s[j]) begin
              cell_r[TOP][j] <= {1'b0, spawn_type_s[j]};
              if (is_two_row(spawn_type_s[j])) begin
                pend_r[j] <= {1'b1, spawn_type_s[j]};
              end else begin
                pend_r[j] <= pend_r[j];
              end
            end else begin
              cell_r[TOP][j] <= cell_r[TOP][j];
            end
          end
        end
        default: begin
          for (int j = 0; j < NUM_LANES; j++) begin
            pend_r[j] <= pend_r[j];
          end
        end
      endcase
    end
  end

  // Registered renderer-facing outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r     <= 1'b0;
      first_row_r <= 1'b0;
      obstacle_r  <= {OBS_W{1'b0}};
      done_r      <= 1'b0;
    end else begin
      valid_r     <= out_valid_s;
      first_row_r <= out_valid_s && (row_nxt_s == {ROW_W{1'b0}});
      obstacle_r  <= out_obs_s;
      done_r      <= (state_nxt_s == DONE);
    end
  end

  assign valid     = valid_r;
  assign first_row = first_row_r;
  assign obstacle  = obstacle_r;
  assign done      = done_r;

endmodule

// File: tb/tb_obstacle_field_generator.sv
// Scoreboard bench for obstacle_field_generator: a frame-level field model
// predicts every emitted cell; a negedge monitor pops and compares on handshake.
module tb_obstacle_field_generator;

  localparam int          NL     = 3;
  localparam int          NR     = 16;
  localparam int          RD     = 64;
  localparam int          DW     = 11;
  localparam int          TH     = 160;
  localparam logic [63:0] SEED_P = 64'h0;   // must behave as seed 1

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        activate = 1'b0;
  logic [5:0]  speed = 6'd0;
  logic        ready = 1'b1;
  logic        valid;
  logic        first_row;
  logic [16:0] obstacle;
  logic        done;

  obstacle_field_generator #(
    .NUM_LANES(NL), .NUM_ROWS(NR), .ROW_DEPTH(RD), .DEPTH_W(DW),
    .SPAWN_THRESH(TH), .SEED(SEED_P)
  ) dut (
    .clk(clk), .rst_n(rst_n), .activate(activate), .speed(speed), .ready(ready),
    .valid(valid), .first_row(first_row), .obstacle(obstacle), .done(done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Clock edges seen since reset release; the LFSR has stepped this many times.
  int ncyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ncyc <= 0;
    else        ncyc <= ncyc + 1;
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [16:0] obs;
    logic        fr;
  } exp_t;

  exp_t        exp_q[$];
  logic [3:0]  m_cell [NR][NL];   // {back_half, type}
  logic [3:0]  m_pend [NL];       // {pending, type}
  int          m_off;
  logic [63:0] m_lfsr;
  int          m_lfsr_n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Polynomial x^64+x^63+x^61+x^60+1, shifting toward bit 0.
  function automatic logic [63:0] galois_step(input logic [63:0] s);
    logic [63:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 64'hD800_0000_0000_0000;
    return n;
  endfunction

  function automatic logic [2:0] kind_of(input int t);
    if (t == 0)      return 3'b001;
    else if (t == 1) return 3'b010;
    else if (t <= 3) return 3'b011;
    else if (t <= 6) return 3'b100;
    else             return 3'b101;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NR; r++)
      for (int j = 0; j < NL; j++) m_cell[r][j] = 4'h0;
    for (int j = 0; j < NL; j++) m_pend[j] = 4'h0;
    m_off    = 0;
    m_lfsr   = 64'h1;
    m_lfsr_n = 0;
  endtask

  // One frame: scroll, optional shift+spawn, then queue every occupied cell.
  task automatic model_frame(input int spd, input int gen_n, output bit wrapped);
    int          sum, p, t, occ;
    bit          cand [NL];
    logic [2:0]  kind [NL];
    logic [63:0] tmp;
    exp_t        e;
    sum     = m_off + spd;
    wrapped = (sum >= RD);
    m_off   = sum % RD;
    if (wrapped) begin
      for (int r = 0; r < NR - 1; r++)
        for (int j = 0; j < NL; j++) m_cell[r][j] = m_cell[r+1][j];
      for (int j = 0; j < NL; j++) begin
        m_cell[NR-1][j] = m_pend[j][3] ? {1'b1, m_pend[j][2:0]} : 4'h0;
        m_pend[j] = 4'h0;
      end
      while (m_lfsr_n < gen_n) begin
        m_lfsr = galois_step(m_lfsr);
        m_lfsr_n++;
      end
      occ = 0;
      for (int j = 0; j < NL; j++) begin
        tmp     = m_lfsr >> (11 * j);
        p       = int'(tmp[7:0]);
        t       = int'(tmp[10:8]);
        kind[j] = kind_of(t);
        cand[j] = (p < TH) && (m_cell[NR-1][j] == 4'h0) && (m_cell[NR-2][j] == 4'h0);
        if (cand[j] || (m_cell[NR-1][j] != 4'h0)) occ++;
      end
      if (occ == NL) begin
        for (int j = NL - 1; j >= 0; j--) begin
          if (cand[j]) begin
            cand[j] = 1'b0;
            break;
          end
        end
      end
      for (int j = 0; j < NL; j++) begin
        if (cand[j]) begin
          m_cell[NR-1][j] = {1'b0, kind[j]};
          if (kind[j] >= 3'b100) m_pend[j] = {1'b1, kind[j]};
        end
      end
    end
    for (int r = 0; r < NR; r++) begin
      for (int j = 0; j < NL; j++) begin
        if (m_cell[r][j][2:0] != 3'b000) begin
          e.obs = {m_cell[r][j], 2'(j), 11'((r + 1) * RD - m_off)};
          e.fr  = (r == 0);
          exp_q.push_back(e);
        end
      end
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t        e;
    logic        held_v;
    logic [16:0] held_obs;
    logic        held_fr;
    held_v = 1'b0;
    held_obs = 17'h0;
    held_fr = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held_v = 1'b0;
      end else begin
        if (held_v) begin
          check("stall_valid_held", 32'(valid), 32'd1);
          check("stall_obstacle_stable", 32'(obstacle), 32'(held_obs));
          check("stall_first_row_stable", 32'(first_row), 32'(held_fr));
        end
        if (valid && ready) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_cell: got obstacle %0h, expected no cell (t=%0t)", obstacle, $time);
          end else begin
            e = exp_q.pop_front();
            check("obstacle", 32'(obstacle), 32'(e.obs));
            check("first_row", 32'(first_row), 32'(e.fr));
          end
        end
        if (done) check("cells_left_at_done", 32'(exp_q.size()), 32'd0);
        held_v   = valid && !ready;
        held_obs = obstacle;
        held_fr  = first_row;
      end
    end
  end

  // ---------------- stimulus ----------------
  // mode 0: ready high, latency checked; 1: random ready; 2: 5-cycle stall on first valid
  task automatic run_frame(input int spd, input int mode);
    bit wrapped;
    int edges, base, stalls_left, stalls;
    @(posedge clk); #1;
    activate = 1'b1;
    speed    = 6'(spd);
    @(posedge clk); #1;
    activate = 1'b0;
    model_frame(spd, ncyc + 2, wrapped);
    base        = wrapped ? (3 + NR * NL) : (1 + NR * NL);
    stalls_left = (mode == 2) ? 5 : 0;
    stalls      = 0;
    edges       = 0;
    ready       = 1'b1;
    while (!done && edges < 2000) begin
      @(posedge clk);
      edges++;
      #1;
      case (mode)
        1: ready = ($urandom_range(0, 2) != 0);
        2: begin
          if (valid && stalls_left > 0) begin
            ready = 1'b0;
            stalls_left--;
            stalls++;
          end else begin
            ready = 1'b1;
          end
        end
        default: ready = 1'b1;
      endcase
    end
    if (edges >= 2000) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done after %0d cycles, expected done", edges);
    end else if (mode != 1) begin
      check("frame_latency", 32'(edges), 32'(base + stalls));
    end
    ready = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit wrapped;
    int edges;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_first_row", 32'(first_row), 32'd0);
    check("reset_obstacle", 32'(obstacle), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_valid", 32'(valid), 32'd0);
    check("idle_done", 32'(done), 32'd0);

    run_frame(0, 0);                       // no scroll, empty field
    repeat (4) run_frame(16, 0);           // wrap on the fourth
    repeat (20) run_frame(63, 0);          // wraps every frame once offset >= 1
    for (int k = 0; k < 30; k++) begin
      case ($urandom_range(0, 3))
        0:       run_frame(0, 1);
        1:       run_frame(63, 1);
        default: run_frame(int'($urandom_range(0, 63)), 1);
      endcase
    end
    run_frame(0, 2);                       // backpressure

    // Reset in the middle of a frame, holding a cell on the output.
    @(posedge clk); #1;
    activate = 1'b1;
    speed    = 6'd0;
    @(posedge clk); #1;
    activate = 1'b0;
    ready    = 1'b0;
    model_frame(0, ncyc + 2, wrapped);
    if (exp_q.size() != 0) begin
      edges = 0;
      while (!valid && edges < 200) begin
        @(posedge clk);
        edges++;
        #1;
      end
      check("mid_emit_valid_seen", 32'(valid), 32'd1);
    end
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_valid", 32'(valid), 32'd0);
    check("async_reset_obstacle", 32'(obstacle), 32'd0);
    check("async_reset_first_row", 32'(first_row), 32'd0);
    exp_q.delete();
    model_reset();
    ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_frame(0, 0);                       // field must be empty again
    run_frame(63, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
